// File: rtl/pulse_train_pkg.sv
// Shared encodings for the pulse train generator: FSM states, run modes and
// the helper that folds the reserved mode value onto one-shot.
package pulse_train_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ONE   = 2'd0;
  localparam logic [1:0] MODE_BURST = 2'd1;
  localparam logic [1:0] MODE_CONT  = 2'd2;

  // Mode 2'b11 behaves exactly like one-shot, so it is folded at latch time.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_ONE : m;
  endfunction

endpackage

// File: rtl/pulse_phase_cnt.sv
// Loadable down-counter timing one HIGH or LOW phase; expired flags the last
// cycle of the phase. Load has priority over decrement and the count never wraps.
module pulse_phase_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse generator: one-shot, counted burst or continuous train.
// Optional sticky done interrupt is enabled with macro PULSE_TRAIN_DONE_IRQ_EN.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int   CNT_W    = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] cnt,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
`ifdef PULSE_TRAIN_DONE_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             irq
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Phase counter is loaded with length-1; a zero length behaves as one cycle.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : (v - ONE);
  endfunction

  state_e           state_q;
  logic             pulse_q, busy_q, done_q;
  logic [CNT_W-1:0] left_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] width_q, gap_q;

  logic             load_s, en_s, expired_s;
  logic [CNT_W-1:0] load_val_s;
  logic [1:0]       start_mode_s;

  assign start_mode_s = norm_mode(mode);

  pulse_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .en       (en_s),
    .expired  (expired_s)
  );

  always_comb begin
    load_s     = 1'b0;
    en_s       = 1'b0;
    load_val_s = len_m1(width);
    case (state_q)
      ST_IDLE: begin
        load_s = start & ~stop;
      end
      ST_HIGH: begin
        if (expired_s) begin
          load_s     = 1'b1;
          load_val_s = len_m1(gap_q);
        end else begin
          en_s = 1'b1;
        end
      end
      ST_LOW: begin
        if (expired_s) begin
          load_s     = 1'b1;
          load_val_s = len_m1(width_q);
        end else begin
          en_s = 1'b1;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pulse_q <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
      mode_q  <= 2'd0;
      width_q <= '0;
      gap_q   <= '0;
    end else if (stop) begin
      state_q <= ST_IDLE;
      pulse_q <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= start_mode_s;
            width_q <= width;
            gap_q   <= gap;
            // An empty burst completes immediately without leaving IDLE.
            if ((start_mode_s == MODE_BURST) && (cnt == '0)) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_HIGH;
              pulse_q <= ~IDLE_LVL;
              busy_q  <= 1'b1;
              left_q  <= (start_mode_s == MODE_BURST) ? cnt : '0;
            end
          end
        end
        ST_HIGH: begin
          if (expired_s) begin
            if ((mode_q == MODE_CONT) || ((mode_q == MODE_BURST) && (left_q != ONE))) begin
              state_q <= ST_LOW;
              pulse_q <= IDLE_LVL;
              if (mode_q == MODE_BURST) begin
                left_q <= left_q - ONE;
              end
            end else begin
              state_q <= ST_IDLE;
              pulse_q <= IDLE_LVL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              left_q  <= '0;
            end
          end
        end
        ST_LOW: begin
          if (expired_s) begin
            state_q <= ST_HIGH;
            pulse_q <= ~IDLE_LVL;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pulse_q <= IDLE_LVL;
          busy_q  <= 1'b0;
          left_q  <= '0;
        end
      endcase
    end
  end

  assign pulse       = pulse_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulses_left = left_q;

`ifdef PULSE_TRAIN_DONE_IRQ_EN
  logic irq_q;

  // Sticky completion flag; a new done wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (done_q) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: a run-level model expands each run into
// the expected per-cycle waveform; a negedge monitor compares it against the DUT.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] mode;
  logic [7:0] width, gap, cnt;
  logic       pulse, busy, done;
  logic [7:0] pulses_left;
`ifdef PULSE_TRAIN_DONE_IRQ_EN
  logic       irq_clr, irq;
  logic       irq_exp = 1'b0;
`endif

  pulse_train_gen #(.CNT_W(8), .IDLE_LVL(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .width(width), .gap(gap), .cnt(cnt),
    .pulse(pulse), .busy(busy), .done(done), .pulses_left(pulses_left)
`ifdef PULSE_TRAIN_DONE_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic p;
    logic b;
    logic d;
    int   left;
  } exp_t;

  exp_t sb[$];
  exp_t trace[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  // Expand one run into its output waveform from the run rules alone.
  task automatic gen_trace(input logic [1:0] m_raw, input int w, input int g, input int n, input int cap);
    int mm, ew, eg, np;
    mm = (m_raw == 2'd3) ? 0 : int'(m_raw);
    ew = (w == 0) ? 1 : w;
    eg = (g == 0) ? 1 : g;
    trace.delete();
    if (mm == 1 && n == 0) begin
      trace.push_back('{0, 1'b0, 1'b0, 1'b1, 0});
      return;
    end
    np = (mm == 0) ? 1 : (mm == 1) ? n : 1000000;
    for (int k = 0; k < np && trace.size() < cap; k++) begin
      for (int i = 0; i < ew; i++) trace.push_back('{0, 1'b1, 1'b1, 1'b0, (mm == 1) ? n - k : 0});
      if (k < np - 1)
        for (int i = 0; i < eg; i++) trace.push_back('{0, 1'b0, 1'b1, 1'b0, (mm == 1) ? n - k - 1 : 0});
    end
    if (mm != 2) trace.push_back('{0, 1'b0, 1'b0, 1'b1, 0});
  endtask

  // abort_at: 0 none, -1 stop together with start, >0 stop/rst in that run cycle.
  task automatic run(input logic [1:0] m, input int w, input int g, input int n,
                     input int abort_at, input bit abort_rst);
    int   t0, len, cap;
    exp_t e;
    cap = (abort_at > 0) ? abort_at : (abort_at < 0) ? 1 : (1 << 30);
    if (m == 2'd2 && cap > 1000) cap = 64;
    gen_trace(m, w, g, n, cap);
    @(posedge clk); #1;
    t0 = cyc;
    mode = m; width = 8'(w); gap = 8'(g); cnt = 8'(n);
    start = 1'b1; stop = (abort_at < 0); rst = 1'b0;
    sb.push_back('{t0, 1'b0, 1'b0, 1'b0, 0});
    if (abort_at < 0) len = 0;
    else begin
      len = trace.size();
      if (abort_at > 0 && abort_at < len) len = abort_at;
    end
    for (int i = 0; i < len; i++) begin
      e = trace[i];
      e.cyc = t0 + 1 + i;
      sb.push_back(e);
    end
    for (int r = 1; r <= len; r++) begin
      @(posedge clk); #1;
      start = trace[r-1].b && ($urandom_range(0, 3) == 0);
      mode  = 2'($urandom);
      width = 8'($urandom);
      gap   = 8'($urandom);
      cnt   = 8'($urandom);
      stop  = (r == abort_at) && !abort_rst;
      rst   = (r == abort_at) && abort_rst;
    end
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; rst = 1'b0;
      sb.push_back('{cyc, 1'b0, 1'b0, 1'b0, 0});
    end
  endtask

  // Monitor: compare every cycle that has an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc == cyc) begin
          check("pulse", 32'(pulse), 32'(e.p));
          check("busy", 32'(busy), 32'(e.b));
          check("done", 32'(done), 32'(e.d));
          check("pulses_left", 32'(pulses_left), e.left);
`ifdef PULSE_TRAIN_DONE_IRQ_EN
          check("irq", 32'(irq), 32'(irq_exp));
          irq_exp = rst ? 1'b0 : (e.d | (irq_exp & ~irq_clr));
`endif
        end
      end
    end
  end

`ifdef PULSE_TRAIN_DONE_IRQ_EN
  initial begin
    irq_clr = 1'b0;
    forever begin
      @(posedge clk); #1;
      irq_clr = ($urandom_range(0, 3) == 0);
    end
  end
`endif

  initial begin
    logic [1:0] m;
    int         w, g, n, ab;
    bit         ab_rst;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    mode = 2'd0; width = 8'd0; gap = 8'd0; cnt = 8'd0;
    @(posedge clk); #1;
    sb.push_back('{cyc, 1'b0, 1'b0, 1'b0, 0});
    @(posedge clk); #1;
    sb.push_back('{cyc, 1'b0, 1'b0, 1'b0, 0});
    rst = 1'b0;

    run(2'd0, 3, 0, 0, 0, 1'b0);
    run(2'd1, 2, 1, 3, 0, 1'b0);
    run(2'd2, 1, 0, 0, 10, 1'b0);
    run(2'd1, 0, 0, 0, 0, 1'b0);
    run(2'd3, 2, 2, 0, 0, 1'b0);
    run(2'd2, 2, 3, 0, 15, 1'b0);
    run(2'd0, 255, 0, 0, 0, 1'b0);
    run(2'd1, 1, 1, 4, 5, 1'b1);
    run(2'd2, 1, 1, 0, -1, 1'b0);
    run(2'd1, 3, 2, 2, 4, 1'b0);

    repeat (40) begin
      m  = 2'($urandom_range(0, 3));
      w  = $urandom_range(0, 5);
      g  = $urandom_range(0, 5);
      n  = $urandom_range(0, 4);
      ab_rst = ($urandom_range(0, 4) == 0);
      if (m == 2'd2) ab = $urandom_range(1, 30);
      else if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, 8);
      else ab = 0;
      if ($urandom_range(0, 9) == 0) ab = -1;
      run(m, w, g, n, ab, ab_rst);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
